// File: rtl/tick_bcd_counter.sv
// N-digit BCD event counter driven by a fixed or LFSR-randomised tick prescaler,
// with up/down counting, pause/clear and a time-multiplexed 7-segment scan.
module tick_bcd_counter #(
  parameter int                    DIGITS     = 4,
  parameter int                    DIV_WIDTH  = 16,
  parameter int                    MAX_COUNT  = 10000,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 8'hB8,
  parameter int                    RAND_BASE  = 8192,
  parameter int                    RAND_SHIFT = 5,
  parameter int                    SCAN_DIV   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    mode_rand,
  input  logic                    count_down,
  input  logic                    pause,
  input  logic                    clear,
  output logic                    tick,
  output logic                    carry,
  output logic [4*DIGITS-1:0]     bcd,
  output logic [DIGITS-1:0]       dig_sel,
  output logic [6:0]              seg,
  output logic [LFSR_WIDTH-1:0]   lfsr
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_WIDTH-1:0]  cnt;
  logic [DIV_WIDTH-1:0]  cmp;
  logic                  step;
  logic [BCD_W:0]        bcd_next;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [3:0]            sel_digit;

  // Ripple one BCD step across all digits; MSB of the result is the wrap flag.
  function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] v,
                                                input logic             down);
    logic [BCD_W-1:0] r;
    logic             c;
    logic [3:0]       d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (down) begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*k +: 4] = d;
    end
    return {c, r};
  endfunction

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    cmp = mode_rand ? (DIV_WIDTH'(RAND_BASE) + (DIV_WIDTH'(lfsr) << RAND_SHIFT))
                    : DIV_WIDTH'(MAX_COUNT);
    step      = (cnt >= cmp);
    bcd_next  = bcd_step(bcd, count_down);
    lfsr_next = lfsr_step(lfsr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bcd      <= '0;
      tick     <= 1'b0;
      carry    <= 1'b0;
      lfsr     <= LFSR_WIDTH'(1);
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (ena) begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      tick  <= 1'b0;
      carry <= 1'b0;
      // clear outranks pause, which outranks a pending step
      if (clear) begin
        cnt <= '0;
        bcd <= '0;
      end else if (!pause) begin
        if (step) begin
          cnt   <= '0;
          tick  <= 1'b1;
          lfsr  <= lfsr_next;
          bcd   <= bcd_next[BCD_W-1:0];
          carry <= bcd_next[BCD_W];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
    end
  end

  always_comb begin
    sel_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) sel_digit = bcd[4*i +: 4];
    end
    dig_sel = DIGITS'(1) << dig_idx;
    seg     = seg_decode(sel_digit);
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: 2 digits, MAX_COUNT=3, SCAN_DIV=2, 8-bit LFSR.
module tb_tick_bcd_counter;

  logic       clk = 1'b0;
  logic       rst_n, ena, mode_rand, count_down, pause, clear;
  logic       tick, carry;
  logic [7:0] bcd;
  logic [1:0] dig_sel;
  logic [6:0] seg;
  logic [7:0] lfsr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_bcd_counter #(
    .DIGITS(2), .DIV_WIDTH(16), .MAX_COUNT(3), .LFSR_WIDTH(8), .LFSR_TAPS(8'hB8),
    .RAND_BASE(8192), .RAND_SHIFT(5), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode_rand(mode_rand),
    .count_down(count_down), .pause(pause), .clear(clear),
    .tick(tick), .carry(carry), .bcd(bcd), .dig_sel(dig_sel), .seg(seg), .lfsr(lfsr)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until tick is seen; n = edges taken, or -1 if the budget ran out.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (tick !== 1'b1 && n < limit);
    if (tick !== 1'b1) n = -1;
  endtask

  task automatic do_reset(input logic rand_mode, input logic en);
    rst_n = 1'b0; ena = en; mode_rand = rand_mode;
    count_down = 1'b0; pause = 1'b0; clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] lfsr_exp [4];
    logic       exp_tick;
    lfsr_exp = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    rst_n = 1'b0; ena = 1'b1; mode_rand = 1'b0;
    count_down = 1'b0; pause = 1'b0; clear = 1'b0;
    #12;
    total++; if (tick !== 1'b0 || carry !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", tick, carry); end
    total++; if (bcd !== 8'h00) begin bad++; $display("FAIL reset_bcd got=%h want=00", bcd); end
    total++; if (lfsr !== 8'h01) begin bad++; $display("FAIL reset_lfsr got=%h want=01", lfsr); end
    total++; if (dig_sel !== 2'b01 || seg !== 7'h3F) begin bad++; $display("FAIL reset_scan got=%b/%h want=01/3f", dig_sel, seg); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp_tick = (k % 4 == 0);
      total++; if (tick !== exp_tick) begin bad++; $display("FAIL fixed_tick cycle=%0d got=%b want=%b", k, tick, exp_tick); end
      if (k % 4 == 0) begin
        total++; if (bcd !== to_bcd(k / 4)) begin bad++; $display("FAIL fixed_bcd got=%h want=%h", bcd, to_bcd(k / 4)); end
        total++; if (lfsr !== lfsr_exp[k / 4]) begin bad++; $display("FAIL fixed_lfsr got=%h want=%h", lfsr, lfsr_exp[k / 4]); end
      end
    end
  endtask

  task automatic test_up_wrap();
    int n;
    int exp_v = 3;
    for (int i = 0; i < 96 && exp_v != 99; i++) begin
      wait_tick(10, n);
      exp_v++;
      total++; if (n !== 4 || bcd !== to_bcd(exp_v)) begin bad++; $display("FAIL up_step got=%0d/%h want=4/%h", n, bcd, to_bcd(exp_v)); end
      if (exp_v == 10) begin
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL up_09_10_carry got=%b want=0", carry); end
      end
    end
    wait_tick(10, n);
    total++; if (bcd !== 8'h00 || carry !== 1'b1) begin bad++; $display("FAIL up_wrap got=%h/%b want=00/1", bcd, carry); end
    cycle();
    total++; if (carry !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL up_wrap_pulse got=%b%b want=00", carry, tick); end
  endtask

  task automatic test_down_wrap();
    int n;
    int exp_v = 99;
    count_down = 1'b1;
    wait_tick(10, n);
    total++; if (bcd !== 8'h99 || carry !== 1'b1) begin bad++; $display("FAIL down_wrap got=%h/%b want=99/1", bcd, carry); end
    for (int i = 0; i < 90 && exp_v != 9; i++) begin
      wait_tick(10, n);
      exp_v--;
      total++; if (bcd !== to_bcd(exp_v)) begin bad++; $display("FAIL down_step got=%h want=%h", bcd, to_bcd(exp_v)); end
      if (exp_v == 9) begin
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL down_10_09_carry got=%b want=0", carry); end
      end
    end
  endtask

  task automatic test_toggle_dir();
    int n;
    cycle(); count_down = 1'b0;
    cycle(); count_down = 1'b1;
    cycle(); count_down = 1'b0;
    wait_tick(10, n);
    total++; if (n !== 1 || bcd !== 8'h10) begin bad++; $display("FAIL toggle_dir got=%0d/%h want=1/10", n, bcd); end
  endtask

  task automatic test_random();
    int n;
    do_reset(1'b1, 1'b1);
    wait_tick(20000, n);
    total++; if (n !== 8225 || lfsr !== 8'hB8) begin bad++; $display("FAIL rand_first got=%0d/%h want=8225/b8", n, lfsr); end
    wait_tick(20000, n);
    total++; if (n !== 14081 || lfsr !== 8'h5C) begin bad++; $display("FAIL rand_second got=%0d/%h want=14081/5c", n, lfsr); end
    repeat (10) cycle();
    mode_rand = 1'b0;
    wait_tick(10, n);
    total++; if (n !== 1 || lfsr !== 8'h2E || bcd !== 8'h03) begin bad++; $display("FAIL mode_switch got=%0d/%h/%h want=1/2e/03", n, lfsr, bcd); end
  endtask

  task automatic test_pause();
    int  n;
    logic saw = 1'b0;
    cycle();
    pause = 1'b1;
    repeat (10) begin
      cycle();
      if (tick !== 1'b0) saw = 1'b1;
    end
    pause = 1'b0;
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL pause_tick got=1 want=0"); end
    wait_tick(20, n);
    total++; if (n !== 3 || bcd !== 8'h04) begin bad++; $display("FAIL pause_resume got=%0d/%h want=3/04", n, bcd); end
  endtask

  task automatic test_clear();
    int n;
    repeat (3) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    total++; if (tick !== 1'b0 || bcd !== 8'h00 || lfsr !== 8'h17) begin bad++; $display("FAIL clear_on_step got=%b/%h/%h want=0/00/17", tick, bcd, lfsr); end
    wait_tick(10, n);
    total++; if (n !== 4 || bcd !== 8'h01 || lfsr !== 8'hB3) begin bad++; $display("FAIL after_clear got=%0d/%h/%h want=4/01/b3", n, bcd, lfsr); end
  endtask

  task automatic test_ena();
    int   n;
    logic moved = 1'b0;
    do_reset(1'b0, 1'b0);
    repeat (10) begin
      cycle();
      if (tick !== 1'b0 || bcd !== 8'h00 || lfsr !== 8'h01 || dig_sel !== 2'b01) moved = 1'b1;
    end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL ena_hold_reset got=1 want=0"); end
    ena = 1'b1;
    cycle();
    cycle();
    ena = 1'b0;
    moved = 1'b0;
    repeat (7) begin
      cycle();
      if (tick !== 1'b0 || bcd !== 8'h00 || dig_sel !== 2'b10 || seg !== 7'h3F) moved = 1'b1;
    end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL ena_freeze got=1 want=0"); end
    ena = 1'b1;
    wait_tick(10, n);
    total++; if (n !== 2 || bcd !== 8'h01) begin bad++; $display("FAIL ena_resume got=%0d/%h want=2/01", n, bcd); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_tick(10, n);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (tick !== 1'b0 || carry !== 1'b0 || bcd !== 8'h00 || lfsr !== 8'h01) begin bad++; $display("FAIL async_reset got=%b%b/%h/%h want=00/00/01", tick, carry, bcd, lfsr); end
    total++; if (dig_sel !== 2'b01 || seg !== 7'h3F) begin bad++; $display("FAIL async_reset_scan got=%b/%h want=01/3f", dig_sel, seg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int         n;
    int         guard = 0;
    logic [1:0] prev;
    logic [1:0] exp_sel;
    logic [6:0] exp_seg;
    for (int i = 0; i < 47; i++) wait_tick(10, n);
    pause = 1'b1;
    total++; if (bcd !== 8'h47) begin bad++; $display("FAIL scan_setup got=%h want=47", bcd); end
    do begin
      prev = dig_sel;
      cycle();
      guard++;
    end while (!(prev == 2'b10 && dig_sel == 2'b01) && guard < 8);
    for (int j = 0; j < 8; j++) begin
      exp_sel = ((j / 2) % 2 == 0) ? 2'b01 : 2'b10;
      exp_seg = ((j / 2) % 2 == 0) ? 7'h07 : 7'h66;
      total++; if (dig_sel !== exp_sel || seg !== exp_seg) begin bad++; $display("FAIL scan_%0d got=%b/%h want=%b/%h", j, dig_sel, seg, exp_sel, exp_seg); end
      cycle();
    end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_toggle_dir();
    test_random();
    test_pause();
    test_clear();
    test_ena();
    test_async_reset();
    test_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
